// File: rtl/ram_bus_arbiter.sv
// Round-robin owner of the shared RAM port: one cache client at a time, held for a whole line transfer.
// Latency: grant registered on the request edge; RAM mux and read-data broadcast are combinational.
// Backpressure: non-owners simply wait on req; their strobes are blocked from the RAM and flagged in conflict.
module ram_bus_arbiter #(
   parameter int CLIENTS     = 4,
   parameter int ADDR_WIDTH  = 14,
   parameter int DATA_WIDTH  = 10,
   parameter int TAIL_CYCLES = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CLIENTS-1:0]             req,
   input  logic [CLIENTS*ADDR_WIDTH-1:0]  cl_addr,
   input  logic [CLIENTS-1:0]             cl_read,
   input  logic [CLIENTS-1:0]             cl_write,
   input  logic [CLIENTS*DATA_WIDTH-1:0]  cl_wdata,
   output logic [CLIENTS-1:0]             grant,
   output logic [DATA_WIDTH-1:0]          cl_rdata,
   output logic [ADDR_WIDTH-1:0]          ram_addr,
   output logic                           ram_read,
   output logic                           ram_write,
   output logic [DATA_WIDTH-1:0]          ram_data_in,
   input  logic [DATA_WIDTH-1:0]          ram_data_out,
   input  logic                           conflict_clr,
   output logic                           conflict,
   output logic [CNT_WIDTH-1:0]           hold_cnt,
   output logic [$clog2(CLIENTS)-1:0]     D_OWNER,
   output logic [1:0]                     D_STATE
);

   localparam int OW = $clog2(CLIENTS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [OW-1:0]        owner, owner_nxt;
   logic [OW-1:0]        ptr, ptr_nxt;
   logic [OW-1:0]        win_idx;
   logic [OW-1:0]        owner_inc;
   logic                 win_found;
   logic [CLIENTS-1:0]   grant_nxt;
   logic [1:0]           tail_cnt, tail_nxt;
   logic [CNT_WIDTH-1:0] hold_nxt;
   logic [CNT_WIDTH-1:0] hold_sat;

   // Pick the first requester at or after ptr, wrapping modulo CLIENTS.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < CLIENTS; k++) begin
         if (!win_found && req[(int'(ptr) + k) % CLIENTS]) begin
            win_found = 1'b1;
            win_idx   = OW'((int'(ptr) + k) % CLIENTS);
         end
      end
   end

   assign owner_inc = (owner == OW'(CLIENTS - 1)) ? '0 : owner + 1'b1;
   assign hold_sat  = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;

   // Next-state logic: grant on request, hold while the owner requests, drain the tail, then rotate.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      tail_nxt  = tail_cnt;
      hold_nxt  = hold_cnt;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = OWN;
               owner_nxt = win_idx;
               grant_nxt = CLIENTS'(1) << win_idx;
               hold_nxt  = '0;
            end
         end
         OWN: begin
            hold_nxt = hold_sat;
            if (!req[owner]) begin
               state_nxt = TAIL;
               tail_nxt  = 2'(TAIL_CYCLES - 1);
            end
         end
         TAIL: begin
            // A re-raised req here is deliberately ignored: no re-extension.
            hold_nxt = hold_sat;
            if (tail_cnt == 2'd0) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               ptr_nxt   = owner_inc;
            end else begin
               tail_nxt = tail_cnt - 2'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // State register; reset abandons any transfer and drops grant at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         grant    <= '0;
         tail_cnt <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         ptr      <= ptr_nxt;
         grant    <= grant_nxt;
         tail_cnt <= tail_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Sticky flag for strobes from clients that do not hold the grant; set wins over clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict <= 1'b0;
      end else if (|((cl_read | cl_write) & ~grant)) begin
         conflict <= 1'b1;
      end else if (conflict_clr) begin
         conflict <= 1'b0;
      end
   end

   // Forward only the owner's bus to the RAM; everything is quiet while nobody holds the grant.
   always_comb begin
      ram_addr    = '0;
      ram_read    = 1'b0;
      ram_write   = 1'b0;
      ram_data_in = '0;
      if (|grant) begin
         ram_addr    = cl_addr[int'(owner) * ADDR_WIDTH +: ADDR_WIDTH];
         ram_read    = cl_read[owner];
         ram_write   = cl_write[owner];
         ram_data_in = cl_wdata[int'(owner) * DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign cl_rdata = ram_data_out;
   assign D_OWNER  = owner;
   assign D_STATE  = state;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed scenarios followed by random client traffic.
// Expected values come from a cycle-numbered transaction model of ownership.
// Outputs are sampled 1-2 time units after the rising edge, inputs driven away from it.
module tb_ram_bus_arbiter;

   localparam int C  = 4;
   localparam int AW = 14;
   localparam int DW = 10;
   localparam int T  = 1;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [C-1:0]      req;
   logic [C*AW-1:0]   cl_addr;
   logic [C-1:0]      cl_read;
   logic [C-1:0]      cl_write;
   logic [C*DW-1:0]   cl_wdata;
   logic [C-1:0]      grant;
   logic [DW-1:0]     cl_rdata;
   logic [AW-1:0]     ram_addr;
   logic              ram_read;
   logic              ram_write;
   logic [DW-1:0]     ram_data_in;
   logic [DW-1:0]     ram_data_out;
   logic              conflict_clr;
   logic              conflict;
   logic [CW-1:0]     hold_cnt;
   logic [1:0]        D_OWNER;
   logic [1:0]        D_STATE;

   ram_bus_arbiter #(
      .CLIENTS(C), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAIL_CYCLES(T), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .cl_addr(cl_addr), .cl_read(cl_read),
      .cl_write(cl_write), .cl_wdata(cl_wdata), .grant(grant), .cl_rdata(cl_rdata),
      .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .conflict_clr(conflict_clr),
      .conflict(conflict), .hold_cnt(hold_cnt), .D_OWNER(D_OWNER), .D_STATE(D_STATE)
   );

   always #5 clk = ~clk;

   int checks;
   int errors;
   int cyc;

   // Model: owner index (-1 none), edge number at which the grant is released (-1 not yet known).
   int          m_owner;
   int          m_last;
   int          m_ptr;
   int          m_rel;
   logic [CW-1:0] m_hold;
   logic        m_conf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [C-1:0] exp_grant();
      logic [C-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic int onehot_idx(input logic [C-1:0] g);
      int r;
      r = -1;
      for (int i = 0; i < C; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_rel   = -1;
      m_hold  = '0;
      m_conf  = 1'b0;
   endtask

   // Apply the ownership rules for the edge just taken (number cyc), using pre-edge grant.
   task automatic model_edge();
      logic [C-1:0] g;
      logic found;
      g = exp_grant();
      if (((cl_read | cl_write) & ~g) != '0) m_conf = 1'b1;
      else if (conflict_clr) m_conf = 1'b0;
      if (m_owner < 0) begin
         if (req != '0) begin
            found = 1'b0;
            for (int k = 0; k < C; k++) begin
               if (!found && req[(m_ptr + k) % C]) begin
                  found   = 1'b1;
                  m_owner = (m_ptr + k) % C;
               end
            end
            m_last = m_owner;
            m_hold = '0;
            m_rel  = -1;
         end
      end else begin
         if (m_hold != {CW{1'b1}}) m_hold = m_hold + 1'b1;
         if (m_rel < 0) begin
            if (!req[m_owner]) m_rel = cyc + T;
         end else if (cyc >= m_rel) begin
            m_ptr   = (m_owner + 1) % C;
            m_owner = -1;
            m_rel   = -1;
         end
      end
   endtask

   task automatic check_comb();
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic er, ew;
      ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
      if (m_owner >= 0) begin
         ea = cl_addr[m_owner*AW +: AW];
         ed = cl_wdata[m_owner*DW +: DW];
         er = cl_read[m_owner];
         ew = cl_write[m_owner];
      end
      chk("ram_addr", 64'(ram_addr), 64'(ea));
      chk("ram_data_in", 64'(ram_data_in), 64'(ed));
      chk("ram_read", 64'(ram_read), 64'(er));
      chk("ram_write", 64'(ram_write), 64'(ew));
      chk("cl_rdata", 64'(cl_rdata), 64'(ram_data_out));
   endtask

   task automatic check_regs();
      int es;
      es = (m_owner < 0) ? 0 : ((m_rel < 0) ? 1 : 2);
      chk("grant", 64'(grant), 64'(exp_grant()));
      chk("hold_cnt", 64'(hold_cnt), 64'(m_hold));
      chk("conflict", 64'(conflict), 64'(m_conf));
      chk("d_owner", 64'(D_OWNER), 64'(m_last));
      chk("d_state", 64'(D_STATE), 64'(es));
   endtask

   task automatic cycle();
      #1;
      check_comb();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0; cl_read = '0; cl_write = '0; conflict_clr = 1'b0;
      #1;
      model_reset();
      check_regs();
      check_comb();
      @(posedge clk);
      cyc++;
      #3;
      rst = 1'b0;
   endtask

   task automatic rand_data();
      cl_addr      = (C*AW)'({$urandom(), $urandom()});
      cl_wdata     = (C*DW)'({$urandom(), $urandom()});
      ram_data_out = DW'($urandom());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, ng, held, drop_cyc;
      int order [5];
      int gap [5];
      int exp_order [5];
      int len [C];
      logic [C-1:0] prev_g;

      checks = 0; errors = 0; cyc = 0;
      req = '0; cl_read = '0; cl_write = '0; cl_addr = '0; cl_wdata = '0;
      ram_data_out = '0; conflict_clr = 1'b0; rst = 1'b1;
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
      for (int i = 0; i < C; i++) len[i] = 0;

      // Reset state.
      do_reset();

      // Single client 2 for 33 request cycles with reads while it owns.
      cnt = 0;
      for (int i = 0; i < 36; i++) begin
         rand_data();
         req     = (i < 33) ? 4'b0100 : 4'b0000;
         cl_read = (i < 33 && m_owner == 2) ? 4'b0100 : 4'b0000;
         cycle();
         if (grant == 4'b0100) cnt++;
      end
      cl_read = '0;
      chk("single_grant_cycles", 64'(cnt), 64'(34));
      chk("single_hold_release", 64'(hold_cnt), 64'(34));
      req = 4'b1001;
      cycle();
      chk("single_ptr_next_3", 64'(grant), 64'(4'b1000));
      req = '0;
      for (int i = 0; i < 3; i++) cycle();

      // All clients request together after reset; each holds 5 owned cycles.
      do_reset();
      req = 4'b1111;
      ng = 0; held = 0; drop_cyc = 0; prev_g = '0;
      for (int i = 0; i < 5; i++) begin order[i] = -1; gap[i] = -1; end
      for (int c = 0; c < 300 && ng < 5; c++) begin
         cycle();
         if (grant != '0 && prev_g == '0) begin
            order[ng] = onehot_idx(grant);
            gap[ng]   = cyc - drop_cyc;
            ng++;
            held = 0;
         end
         prev_g = grant;
         if (grant != '0 && onehot_idx(grant) >= 0 && req[onehot_idx(grant)]) begin
            held++;
            if (held == 5) begin
               req[onehot_idx(grant)] = 1'b0;
               drop_cyc = cyc + 1;
            end
         end
         if (grant == '0) req = 4'b1111;
      end
      chk("rr_grant_count", 64'(ng), 64'(5));
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(order[i]), 64'(exp_order[i]));
      for (int i = 1; i < 5; i++) chk("rr_gap", 64'(gap[i]), 64'(1 + T));
      req = '0;
      for (int i = 0; i < 8; i++) cycle();

      // Non-owner strobe while client 1 owns.
      do_reset();
      req = 4'b0010;
      cycle();
      chk("nonowner_setup", 64'(grant), 64'(4'b0010));
      cl_wdata = '0;
      cl_wdata[3*DW +: DW] = 10'h155;
      cl_wdata[1*DW +: DW] = 10'h0AA;
      cl_write = 4'b1000;
      #1;
      chk("nonowner_ram_write", 64'(ram_write), 64'(0));
      chk("nonowner_wdata", 64'(ram_data_in), 64'(10'h0AA));
      cycle();
      chk("conflict_set", 64'(conflict), 64'(1));
      cl_write = '0;
      for (int i = 0; i < 3; i++) cycle();
      chk("conflict_sticky", 64'(conflict), 64'(1));
      conflict_clr = 1'b1;
      cycle();
      conflict_clr = 1'b0;
      chk("conflict_cleared", 64'(conflict), 64'(0));

      // Reset in the middle of client 1's transfer at hold_cnt = 12.
      for (int i = 0; i < 50 && m_hold != 12; i++) begin
         rand_data();
         cl_read = (m_owner == 1) ? 4'b0010 : 4'b0000;
         cycle();
      end
      cl_read = '0;
      chk("pre_rst_hold", 64'(hold_cnt), 64'(12));
      rst = 1'b1;
      #1;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_hold", 64'(hold_cnt), 64'(0));
      chk("rst_state", 64'(D_STATE), 64'(0));
      model_reset();
      @(posedge clk);
      cyc++;
      #3;
      rst = 1'b0;
      req = 4'b0010;
      cycle();
      chk("post_rst_grant", 64'(grant), 64'(4'b0010));
      req = '0;
      for (int i = 0; i < 3; i++) cycle();

      // Client 0 drops and re-raises in TAIL while client 2 waits.
      do_reset();
      req = 4'b0101;
      cycle();
      chk("tail_setup", 64'(grant), 64'(4'b0001));
      for (int i = 0; i < 3; i++) cycle();
      req = 4'b0100;
      cycle();
      chk("tail_still_owned", 64'(grant), 64'(4'b0001));
      req = 4'b0101;
      cycle();
      chk("tail_release", 64'(grant), 64'(4'b0000));
      cycle();
      chk("tail_next_owner", 64'(grant), 64'(4'b0100));
      req = '0;
      for (int i = 0; i < 4; i++) cycle();

      // Random traffic against the model.
      do_reset();
      for (int it = 0; it < 3000; it++) begin
         rand_data();
         for (int i = 0; i < C; i++) begin
            if (m_owner == i && m_rel < 0 && req[i]) begin
               if (len[i] <= 1) req[i] = 1'b0;
               else len[i]--;
            end else if (!req[i] && $urandom_range(0, 5) == 0) begin
               req[i] = 1'b1;
               len[i] = $urandom_range(1, 12);
            end
         end
         cl_read  = '0;
         cl_write = '0;
         if (m_owner >= 0) begin
            cl_read[m_owner]  = 1'($urandom_range(0, 1));
            cl_write[m_owner] = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 40) == 0) cl_write[$urandom_range(0, C-1)] = 1'b1;
         conflict_clr = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
